alarm_sound_sched: RTL



---
 rtl/alarm_sound_sched.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/alarm_sound_sched.sv
// Sound-resource scheduler: arbitrates alarm, hourly chime and key beep onto the
// shared melody player and beep tone, and sequences alarm ring, snooze and timeout.
module alarm_sound_sched #(
  parameter int SEC_CYCLES      = 1000000,
  parameter int ALARM_TIMEOUT_S = 60,
  parameter int SNOOZE_S        = 300,
  parameter int SNOOZE_MAX      = 3,
  parameter int CHIME_S         = 5,
  parameter int BEEP_CYCLES     = 100000,
  parameter int DEB_LEN         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alarm_req,
  input  logic       chime_req,
  input  logic       beep_req,
  input  logic       stop_btn,
  input  logic       snooze_btn,
  output logic       melody_en,
  output logic       song_sel,
  output logic       beep_en,
  output logic [2:0] state,
  output logic [1:0] snooze_left
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BEEP   = 3'd1,
    ST_CHIME  = 3'd2,
    ST_ALARM  = 3'd3,
    ST_SNOOZE = 3'd4,
    ST_GAP    = 3'd5
  } state_t;

  localparam int SEC_W  = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
  localparam int EL_MAX = (ALARM_TIMEOUT_S > SNOOZE_S) ?
                          ((ALARM_TIMEOUT_S > CHIME_S) ? ALARM_TIMEOUT_S : CHIME_S) :
                          ((SNOOZE_S > CHIME_S) ? SNOOZE_S : CHIME_S);
  localparam int EL_W   = (EL_MAX > 0) ? $clog2(EL_MAX + 1) : 1;
  localparam int BEEP_W = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;

  state_t            cur_state;
  state_t            next_state;
  logic [1:0]        next_left;
  logic              alarm_restart;
  logic              beep_restart;
  logic              melody_d;
  logic              song_d;
  logic              beep_d;

  logic [DEB_LEN-1:0] stop_sh;
  logic [DEB_LEN-1:0] snooze_sh;
  logic               stop_q;
  logic               snooze_q;
  logic               stop_pressed;
  logic               snooze_pressed;
  logic               stop_ev;
  logic               snooze_ev;

  logic [SEC_W-1:0]  sec_cnt;
  logic [EL_W-1:0]   sec_elapsed;
  logic [BEEP_W-1:0] beep_cnt;
  logic              tick;
  logic              sec_clear;
  logic              chime_done;
  logic              alarm_done;
  logic              snooze_done;
  logic              beep_done;

  // A button counts as pressed once DEB_LEN consecutive samples are high; the event is its rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      stop_sh   <= '0;
      snooze_sh <= '0;
      stop_q    <= 1'b0;
      snooze_q  <= 1'b0;
    end else begin
      stop_sh   <= (stop_sh << 1) | DEB_LEN'(stop_btn);
      snooze_sh <= (snooze_sh << 1) | DEB_LEN'(snooze_btn);
      stop_q    <= stop_pressed;
      snooze_q  <= snooze_pressed;
    end
  end

  assign stop_pressed   = &stop_sh;
  assign snooze_pressed = &snooze_sh;
  assign stop_ev        = stop_pressed & ~stop_q;
  assign snooze_ev      = snooze_pressed & ~snooze_q;

  assign tick        = (sec_cnt == SEC_W'(SEC_CYCLES - 1));
  assign sec_clear   = (next_state != cur_state) || alarm_restart;
  assign chime_done  = (sec_elapsed == EL_W'(CHIME_S));
  assign alarm_done  = (sec_elapsed == EL_W'(ALARM_TIMEOUT_S));
  assign snooze_done = (sec_elapsed == EL_W'(SNOOZE_S));
  assign beep_done   = (beep_cnt == BEEP_W'(BEEP_CYCLES - 1));

  // Second timebase restarts on every state entry so each timeout is measured from entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      sec_cnt     <= '0;
      sec_elapsed <= '0;
      beep_cnt    <= '0;
    end else begin
      if (sec_clear) begin
        sec_cnt     <= '0;
        sec_elapsed <= '0;
      end else if (tick) begin
        sec_cnt     <= '0;
        sec_elapsed <= sec_elapsed + 1'b1;
      end else begin
        sec_cnt     <= sec_cnt + 1'b1;
      end
      if ((cur_state == ST_BEEP) && (next_state == ST_BEEP) && !beep_restart)
        beep_cnt <= beep_cnt + 1'b1;
      else
        beep_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state   <= ST_IDLE;
      melody_en   <= 1'b0;
      song_sel    <= 1'b0;
      beep_en     <= 1'b0;
      snooze_left <= 2'(SNOOZE_MAX);
    end else begin
      cur_state   <= next_state;
      melody_en   <= melody_d;
      song_sel    <= song_d;
      beep_en     <= beep_d;
      snooze_left <= next_left;
    end
  end

  assign state = cur_state;

  // Stop outranks everything; a request losing arbitration is simply discarded.
  always_comb begin
    next_state    = cur_state;
    next_left     = snooze_left;
    alarm_restart = 1'b0;
    beep_restart  = 1'b0;
    unique case (cur_state)
      ST_IDLE: begin
        if (stop_ev) begin
          next_state = ST_IDLE;
        end else if (alarm_req) begin
          next_state = ST_ALARM;
          next_left  = 2'(SNOOZE_MAX);
        end else if (chime_req) begin
          next_state = ST_CHIME;
        end else if (beep_req) begin
          next_state = ST_BEEP;
        end
      end
      ST_BEEP: begin
        if (stop_ev) begin
          next_state = ST_IDLE;
        end else if (alarm_req) begin
          next_state = ST_ALARM;
          next_left  = 2'(SNOOZE_MAX);
        end else if (chime_req) begin
          next_state = ST_CHIME;
        end else if (beep_req) begin
          beep_restart = 1'b1;
        end else if (beep_done) begin
          next_state = ST_IDLE;
        end
      end
      ST_CHIME: begin
        if (stop_ev) begin
          next_state = ST_IDLE;
        end else if (alarm_req) begin
          next_state = ST_GAP;
          next_left  = 2'(SNOOZE_MAX);
        end else if (chime_done) begin
          next_state = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (stop_ev)
          next_state = ST_IDLE;
        else
          next_state = ST_ALARM;
      end
      ST_ALARM: begin
        if (stop_ev) begin
          next_state = ST_IDLE;
          next_left  = 2'(SNOOZE_MAX);
        end else if (alarm_req) begin
          alarm_restart = 1'b1;
        end else if (snooze_ev && (snooze_left != 2'd0)) begin
          next_state = ST_SNOOZE;
          next_left  = snooze_left - 2'd1;
        end else if (alarm_done) begin
          next_state = ST_IDLE;
        end
      end
      ST_SNOOZE: begin
        if (stop_ev) begin
          next_state = ST_IDLE;
          next_left  = 2'(SNOOZE_MAX);
        end else if (alarm_req || snooze_done) begin
          next_state = ST_ALARM;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    melody_d = 1'b0;
    song_d   = 1'b0;
    beep_d   = 1'b0;
    unique case (next_state)
      ST_BEEP:  beep_d = 1'b1;
      ST_CHIME: begin
        melody_d = 1'b1;
        song_d   = 1'b1;
      end
      ST_ALARM: melody_d = 1'b1;
      default: begin
        melody_d = 1'b0;
        song_d   = 1'b0;
        beep_d   = 1'b0;
      end
    endcase
  end

endmodule
